// File: rtl/detect_pkg.sv
// Shared types and constants for the detection event counter.
package detect_pkg;

    // Gap tracker state: IDLE until the first detection, TRACK afterwards.
    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } gap_state_t;

    // Default width of the gap measurement.
    localparam int GAP_BITS_DEFAULT = 8;

    // Gap value meaning "no previous detection" or "gap too long to measure".
    localparam logic [GAP_BITS_DEFAULT-1:0] GAP_NONE = '1;

endpackage

// File: rtl/flex_counter.sv
// Event counter with programmable rollover value and synchronous clear.
// The count wraps to 1 after reaching rollover_val.
// If rollover_val is lowered below the current count, the count keeps
// incrementing and wraps naturally through zero at the field maximum.
module flex_counter
    import detect_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] r_count;
    logic                    r_flag;
    logic [NUM_CNT_BITS-1:0] w_next_count;
    logic                    w_next_flag;

    // Next count and next rollover flag; the flag tracks the value being loaded.
    always_comb begin
        w_next_count = r_count;
        if (clear) begin
            w_next_count = '0;
        end else if (count_enable) begin
            if (r_count == rollover_val) begin
                w_next_count = CNT_ONE;
            end else begin
                w_next_count = r_count + CNT_ONE;
            end
        end
        w_next_flag = (!clear) && (w_next_count == rollover_val);
    end

    // Count and flag registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
            r_flag  <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_flag  <= w_next_flag;
        end
    end

    assign count_out     = r_count;
    assign rollover_flag = r_flag;

endmodule

// File: rtl/detect_event_counter.sv
// Consumes single-cycle detector pulses: counts them with a programmable
// rollover, measures the enabled-cycle gap between consecutive detections,
// and offers each detection as a {count, gap} report on a valid/ready port.
// A detection arriving while a report is still pending is dropped and
// flagged on the sticky overrun output.
module detect_event_counter
    import detect_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4,
    parameter int GAP_BITS     = 8
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    detect,
    input  logic                    enable,
    input  logic                    clear,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] event_count,
    output logic                    rollover_flag,
    output logic                    report_valid,
    input  logic                    report_ready,
    output logic [NUM_CNT_BITS-1:0] report_count,
    output logic [GAP_BITS-1:0]     report_gap,
    output logic                    overrun
);

    localparam logic [GAP_BITS-1:0] GAP_ALL_ONES = {GAP_BITS{1'b1}};
    localparam logic [GAP_BITS-1:0] GAP_ONE      = GAP_BITS'(1);
    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = NUM_CNT_BITS'(1);

    // A detection only counts when enabled and not overridden by clear.
    logic w_accept;
    assign w_accept = detect && enable && !clear;

    // ------------------------------------------------------------------
    // Event counter
    // ------------------------------------------------------------------
    logic [NUM_CNT_BITS-1:0] w_count;
    logic                    w_flag;

    flex_counter #(
        .NUM_CNT_BITS (NUM_CNT_BITS)
    ) u_counter (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (clear),
        .count_enable  (w_accept),
        .rollover_val  (rollover_val),
        .count_out     (w_count),
        .rollover_flag (w_flag)
    );

    // Count value that the accepted detection produces (what gets reported).
    logic [NUM_CNT_BITS-1:0] w_count_after;
    assign w_count_after = (w_count == rollover_val) ? CNT_ONE : (w_count + CNT_ONE);

    // ------------------------------------------------------------------
    // Gap tracker FSM
    // ------------------------------------------------------------------
    gap_state_t          r_state;
    gap_state_t          w_next_state;
    logic [GAP_BITS-1:0] r_gap_cnt;
    logic [GAP_BITS-1:0] w_next_gap_cnt;
    logic [GAP_BITS-1:0] w_new_gap;

    // State and gap counter registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= IDLE;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_next_state;
            r_gap_cnt <= w_next_gap_cnt;
        end
    end

    // Next state, next gap count, and the gap value to report on a detection.
    always_comb begin
        w_next_state   = r_state;
        w_next_gap_cnt = r_gap_cnt;
        w_new_gap      = GAP_ALL_ONES;
        if (clear) begin
            w_next_state   = IDLE;
            w_next_gap_cnt = '0;
        end else if (enable) begin
            unique case (r_state)
                IDLE: begin
                    w_next_gap_cnt = '0;
                    if (detect) begin
                        w_new_gap      = GAP_ALL_ONES;
                        w_next_state   = TRACK;
                        w_next_gap_cnt = GAP_ONE;
                    end
                end
                TRACK: begin
                    if (detect) begin
                        w_new_gap      = r_gap_cnt;
                        w_next_gap_cnt = GAP_ONE;
                    end else if (r_gap_cnt != GAP_ALL_ONES) begin
                        w_next_gap_cnt = r_gap_cnt + GAP_ONE;
                    end
                end
                default: begin
                    w_next_state   = IDLE;
                    w_next_gap_cnt = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Report register and handshake
    // ------------------------------------------------------------------
    logic                    r_rep_valid;
    logic [NUM_CNT_BITS-1:0] r_rep_count;
    logic [GAP_BITS-1:0]     r_rep_gap;
    logic                    r_overrun;
    logic                    w_slot_free;

    // The slot can take a new report if empty or being drained on this edge.
    assign w_slot_free = !r_rep_valid || report_ready;

    // Load, drain, or overrun-flag the single report slot.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rep_valid <= 1'b0;
            r_rep_count <= '0;
            r_rep_gap   <= '0;
            r_overrun   <= 1'b0;
        end else if (clear) begin
            r_rep_valid <= 1'b0;
            r_rep_count <= '0;
            r_rep_gap   <= '0;
            r_overrun   <= 1'b0;
        end else if (w_accept && w_slot_free) begin
            r_rep_valid <= 1'b1;
            r_rep_count <= w_count_after;
            r_rep_gap   <= w_new_gap;
        end else begin
            if (w_accept) begin
                r_overrun <= 1'b1;
            end
            if (r_rep_valid && report_ready) begin
                r_rep_valid <= 1'b0;
            end
        end
    end

    assign event_count   = w_count;
    assign rollover_flag = w_flag;
    assign report_valid  = r_rep_valid;
    assign report_count  = r_rep_count;
    assign report_gap    = r_rep_gap;
    assign overrun       = r_overrun;

endmodule

// File: tb/tb_detect_event_counter.sv
// Testbench for detect_event_counter: directed scenarios plus a randomized
// run, all compared against a timestamp-based reference model.
module tb_detect_event_counter;

    localparam int N = 4;
    localparam int G = 8;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         detect = 1'b0;
    logic         enable = 1'b1;
    logic         clear = 1'b0;
    logic [N-1:0] rollover_val = 4'd4;
    logic         report_ready = 1'b1;
    logic [N-1:0] event_count;
    logic         rollover_flag;
    logic         report_valid;
    logic [N-1:0] report_count;
    logic [G-1:0] report_gap;
    logic         overrun;

    int checks = 0;
    int errors = 0;

    detect_event_counter #(.NUM_CNT_BITS(N), .GAP_BITS(G)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .detect        (detect),
        .enable        (enable),
        .clear         (clear),
        .rollover_val  (rollover_val),
        .event_count   (event_count),
        .rollover_flag (rollover_flag),
        .report_valid  (report_valid),
        .report_ready  (report_ready),
        .report_count  (report_count),
        .report_gap    (report_gap),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: events counted arithmetically, gaps from timestamps
    // of enabled cycles, one-entry report slot.
    int       m_cnt, m_rc, m_rg;
    bit       m_flag, m_valid, m_ovr, m_have_prev;
    longint   m_time, m_last;

    logic [18:0] obs;
    assign obs = {event_count, rollover_flag, report_valid, report_count, report_gap, overrun};

    function automatic logic [18:0] exp_vec();
        return {N'(m_cnt), m_flag, m_valid, N'(m_rc), G'(m_rg), m_ovr};
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_rc = 0; m_rg = 0;
        m_flag = 0; m_valid = 0; m_ovr = 0; m_have_prev = 0;
        m_time = 0; m_last = 0;
    endtask

    task automatic model_edge(input bit d, input bit en, input bit clr, input bit rdy, input int rv);
        longint diff;
        int gap;
        if (clr) begin
            model_reset();
        end else begin
            if (en) m_time++;
            if (d && en) begin
                m_cnt = (m_cnt == rv) ? 1 : ((m_cnt + 1) % (1 << N));
                if (m_have_prev) begin
                    diff = m_time - m_last;
                    gap = (diff > 255) ? 255 : int'(diff);
                end else begin
                    gap = 255;
                end
                m_last = m_time;
                m_have_prev = 1;
                if (!m_valid || rdy) begin
                    m_valid = 1; m_rc = m_cnt; m_rg = gap;
                end else begin
                    m_ovr = 1;
                end
            end else if (m_valid && rdy) begin
                m_valid = 0;
            end
            m_flag = (m_cnt == rv);
        end
    endtask

    // Apply one cycle of inputs, advance DUT and model, settle 1 time unit after the edge.
    task automatic tick(input bit d, input bit en, input bit clr, input bit rdy);
        detect = d; enable = en; clear = clr; report_ready = rdy;
        @(posedge clk);
        model_edge(d, en, clr, rdy, int'(rollover_val));
        #1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        model_reset();
        #2;
        checks++;
        if (obs !== 19'd0) begin
            errors++; $display("FAIL reset_outputs got %h want %h", obs, 19'd0);
        end
        @(negedge clk);
        n_rst = 1'b1;
        tick(0, 1, 0, 1);
        checks++;
        if (obs !== exp_vec()) begin
            errors++; $display("FAIL reset_idle got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_first_detect();
        rollover_val = 4'd4;
        tick(1, 1, 0, 1);
        checks++;
        if ({event_count, report_valid, report_count, report_gap} !== {4'd1, 1'b1, 4'd1, 8'hFF}) begin
            errors++; $display("FAIL first_detect got cnt=%0d v=%0b rc=%0d rg=%h want 1 1 1 ff",
                               event_count, report_valid, report_count, report_gap);
        end
        tick(0, 1, 0, 1);
        checks++;
        if (report_valid !== 1'b0 || obs !== exp_vec()) begin
            errors++; $display("FAIL first_drain got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_gap_sequence();
        int exp_c [3] = '{1, 2, 3};
        int exp_g [3] = '{255, 3, 1};
        int k = 0;
        tick(0, 1, 1, 1);
        for (int c = 1; c <= 14; c++) begin
            tick((c == 10 || c == 13 || c == 14), 1, 0, 1);
            if (c == 10 || c == 13 || c == 14) begin
                checks++;
                if (report_valid !== 1'b1 || report_count !== N'(exp_c[k]) || report_gap !== G'(exp_g[k])) begin
                    errors++; $display("FAIL gap_seq%0d got v=%0b rc=%0d rg=%0d want 1 %0d %0d",
                                       k, report_valid, report_count, report_gap, exp_c[k], exp_g[k]);
                end
                k++;
            end
        end
    endtask

    task automatic test_rollover();
        int exp_c [5] = '{1, 2, 3, 1, 2};
        rollover_val = 4'd3;
        tick(0, 1, 1, 1);
        for (int i = 0; i < 5; i++) begin
            tick(1, 1, 0, 1);
            checks++;
            if (event_count !== N'(exp_c[i]) || rollover_flag !== (exp_c[i] == 3)) begin
                errors++; $display("FAIL rollover%0d got cnt=%0d flag=%0b want %0d %0b",
                                   i, event_count, rollover_flag, exp_c[i], exp_c[i] == 3);
            end
        end
    endtask

    task automatic test_back_to_back_overrun();
        rollover_val = 4'd4;
        tick(0, 1, 1, 0);
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        checks++;
        if ({report_valid, report_count, report_gap, overrun, event_count} !== {1'b1, 4'd1, 8'hFF, 1'b1, 4'd2}) begin
            errors++; $display("FAIL overrun_hold got v=%0b rc=%0d rg=%h ovr=%0b cnt=%0d want 1 1 ff 1 2",
                               report_valid, report_count, report_gap, overrun, event_count);
        end
        tick(0, 1, 0, 1);
        checks++;
        if (report_valid !== 1'b0 || overrun !== 1'b1) begin
            errors++; $display("FAIL overrun_drain got v=%0b ovr=%0b want 0 1", report_valid, overrun);
        end
        tick(1, 1, 0, 1);
        checks++;
        if (report_valid !== 1'b1 || report_count !== 4'd3 || obs !== exp_vec()) begin
            errors++; $display("FAIL overrun_next got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_saturation();
        tick(0, 1, 1, 1);
        tick(1, 1, 0, 1);
        for (int i = 0; i < 300; i++) tick(0, 1, 0, 1);
        tick(1, 1, 0, 1);
        checks++;
        if (report_gap !== 8'hFF || report_count !== 4'd2) begin
            errors++; $display("FAIL gap_saturate got rg=%h rc=%0d want ff 2", report_gap, report_count);
        end
    endtask

    task automatic test_enable_freeze();
        tick(0, 1, 1, 1);
        tick(1, 1, 0, 0);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 1);
        checks++;
        if ({event_count, report_valid, overrun} !== {4'd1, 1'b0, 1'b0} || obs !== exp_vec()) begin
            errors++; $display("FAIL enable_freeze got %h want %h", obs, exp_vec());
        end
        tick(0, 0, 0, 1);
        tick(1, 1, 0, 1);
        checks++;
        if (report_gap !== 8'd1 || report_count !== 4'd2) begin
            errors++; $display("FAIL enable_gap got rg=%0d rc=%0d want 1 2", report_gap, report_count);
        end
    endtask

    task automatic test_clear();
        tick(1, 1, 0, 0);
        tick(1, 1, 1, 0);
        checks++;
        if (obs !== 19'd0) begin
            errors++; $display("FAIL clear_all got %h want %h", obs, 19'd0);
        end
        tick(1, 1, 0, 1);
        checks++;
        if ({report_valid, report_count, report_gap} !== {1'b1, 4'd1, 8'hFF}) begin
            errors++; $display("FAIL clear_next got v=%0b rc=%0d rg=%h want 1 1 ff",
                               report_valid, report_count, report_gap);
        end
    endtask

    task automatic test_async_reset();
        tick(1, 1, 0, 0);
        tick(0, 1, 0, 0);
        #2;
        n_rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== 19'd0) begin
            errors++; $display("FAIL async_reset got %h want %h", obs, 19'd0);
        end
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_random();
        bit d, en, clr, rdy;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) rollover_val = N'($urandom_range(1, 15));
            d   = ($urandom_range(0, 99) < 35);
            en  = ($urandom_range(0, 99) < 85);
            clr = ($urandom_range(0, 199) < 2);
            rdy = ($urandom_range(0, 99) < 55);
            if (i % 700 > 600) d = ($urandom_range(0, 99) < 1);
            tick(d, en, clr, rdy);
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL random%0d got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_detect();
        test_gap_sequence();
        test_rollover();
        test_back_to_back_overrun();
        test_saturation();
        test_enable_freeze();
        test_clear();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
